// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional parity; pushes one word a clk after the stop sample, no backpressure.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (taken one pulse later).
module uart_rx_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic [1:0] wls,
  input  logic       parity_enable,
  input  logic       even_parity_select,
  input  logic       sticky_parity,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_nx;
  logic       rx_meta, rx_s;
  logic       bit_val;
  logic [3:0] cnt, cnt_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [7:0] data, data_nx;
  logic       par_acc, par_acc_nx;
  logic       zero_acc, zero_acc_nx;
  logic [1:0] frm_wls, frm_wls_nx;
  logic       frm_pen, frm_pen_nx;
  logic       frm_eps, frm_eps_nx;
  logic       frm_stk, frm_stk_nx;
  logic       frm_pe, frm_pe_nx;
  logic       armed, armed_nx;
  logic       push_nx, pe_nx, fe_nx, bi_nx;
  logic [7:0] dout_nx;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] START_PT = 4'd8;
  logic [1:0] hist;

  // hist holds rx_s at the two previous baud pulses (S-1, S) when deciding at S+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             hist <= 2'b11;
    else if (baud_pulse) hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam logic [3:0] START_PT = 4'd7;
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      data     <= '0;
      par_acc  <= 1'b0;
      zero_acc <= 1'b1;
      frm_wls  <= '0;
      frm_pen  <= 1'b0;
      frm_eps  <= 1'b0;
      frm_stk  <= 1'b0;
      frm_pe   <= 1'b0;
      armed    <= 1'b1;
      push     <= 1'b0;
      dout     <= '0;
      pe       <= 1'b0;
      fe       <= 1'b0;
      bi       <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_idx_nx;
      data     <= data_nx;
      par_acc  <= par_acc_nx;
      zero_acc <= zero_acc_nx;
      frm_wls  <= frm_wls_nx;
      frm_pen  <= frm_pen_nx;
      frm_eps  <= frm_eps_nx;
      frm_stk  <= frm_stk_nx;
      frm_pe   <= frm_pe_nx;
      armed    <= armed_nx;
      push     <= push_nx;
      dout     <= dout_nx;
      pe       <= pe_nx;
      fe       <= fe_nx;
      bi       <= bi_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_idx_nx  = bit_idx;
    data_nx     = data;
    par_acc_nx  = par_acc;
    zero_acc_nx = zero_acc;
    frm_wls_nx  = frm_wls;
    frm_pen_nx  = frm_pen;
    frm_eps_nx  = frm_eps;
    frm_stk_nx  = frm_stk;
    frm_pe_nx   = frm_pe;
    armed_nx    = armed;
    push_nx     = 1'b0;
    dout_nx     = dout;
    pe_nx       = pe;
    fe_nx       = fe;
    bi_nx       = bi;

    if (baud_pulse) begin
      case (state)
        IDLE: begin
          if (!armed) begin
            if (rx_s) armed_nx = 1'b1;
          end else if (!rx_s) begin
            state_nx = START;
            cnt_nx   = 4'd1;
          end
        end
        START: begin
          if (cnt == START_PT) begin
            if (bit_val) begin
              state_nx = IDLE;
            end else begin
              state_nx    = DATA;
              cnt_nx      = 4'd1;
              bit_idx_nx  = '0;
              data_nx     = '0;
              par_acc_nx  = 1'b0;
              zero_acc_nx = 1'b1;
              frm_pe_nx   = 1'b0;
              frm_wls_nx  = wls;
              frm_pen_nx  = parity_enable;
              frm_eps_nx  = even_parity_select;
              frm_stk_nx  = sticky_parity;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        // cnt restarts at 1 after each decision and wraps to 0 exactly 16 pulses later
        DATA: begin
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'd0) begin
            data_nx[bit_idx] = bit_val;
            par_acc_nx       = par_acc ^ bit_val;
            zero_acc_nx      = zero_acc & ~bit_val;
            bit_idx_nx       = bit_idx + 3'd1;
            if (bit_idx == ({1'b0, frm_wls} + 3'd4))
              state_nx = frm_pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'd0) begin
            case ({frm_stk, frm_eps})
              2'b00:   frm_pe_nx = ~(par_acc ^ bit_val);
              2'b01:   frm_pe_nx = par_acc ^ bit_val;
              2'b10:   frm_pe_nx = ~bit_val;
              default: frm_pe_nx = bit_val;
            endcase
            zero_acc_nx = zero_acc & ~bit_val;
            state_nx    = STOP;
          end
        end
        STOP: begin
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'd0) begin
            push_nx  = 1'b1;
            dout_nx  = data;
            pe_nx    = frm_pe;
            fe_nx    = ~bit_val;
            bi_nx    = zero_acc & ~bit_val;
            armed_nx = bit_val;
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have a clk input, 1 bit: system clock; all state changes on the rising edge.
REQ-002 SHALL have an rst input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have a baud_pulse input, 1 bit: 1-clk enable at 16x bit rate; all bit timing is counted in baud_pulses.
REQ-004 SHALL have an rx input, 1 bit: serial line, asynchronous, idle high.
REQ-005 SHALL have a wls input, 2 bits: word length; 00=5, 01=6, 10=7, 11=8 data bits.
REQ-006 SHALL have a parity_enable input, 1 bit: a parity bit follows the data bits.
REQ-007 SHALL have an even_parity_select input, 1 bit: 1=even parity, 0=odd parity.
REQ-008 SHALL have a sticky_parity input, 1 bit: 1=expected parity bit is ~even_parity_select.
REQ-009 SHALL have a push output, 1 bit: 1-clk strobe that writes the received word into the RX FIFO.
REQ-010 SHALL have a dout output, 8 bits: received data, LSB first on the line, right-aligned, unused MSBs 0.
REQ-011 SHALL have a pe output, 1 bit: parity error of the word on dout.
REQ-012 SHALL have a fe output, 1 bit: framing error of the word on dout.
REQ-013 SHALL have a bi output, 1 bit: break indication of the word on dout.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; state and counters advance only on baud_pulse.
REQ-016 IDLE: SHALL enter START on a baud_pulse with rx_s=0 and the armed flag set; that pulse is pulse 0.
REQ-017 START: SHALL sample at pulse 7 (mid-bit); sample 0 -> DATA; sample 1 -> false start, return to IDLE without push.
REQ-018 DATA: SHALL sample every 16 pulses after the start sample, shift bits in LSB first, and receive exactly 5+wls bits.
REQ-019 After the last data bit, SHALL go to PARITY if parity_enable=1, else to STOP; the next sample is 16 pulses later.
REQ-020 Parity check, by {sticky_parity, even_parity_select}, checked over the valid data bits plus the parity bit:
  - 00: pe=1 if the XOR is not 1.
  - 01: pe=1 if the XOR is not 0.
  - 10: pe=1 if the parity bit is not 1.
  - 11: pe=1 if the parity bit is not 0.
REQ-021 STOP: SHALL check only the first stop bit; fe=1 if the sampled value is 0; the stop_bit setting is irrelevant to RX.
REQ-022 bi SHALL be 1 when data, parity (if enabled) and stop samples are all 0.
REQ-023 On the clk after the stop sample: push=1 for exactly one clk; dout/pe/fe/bi updated in that same clk and held until the next push.
REQ-024 After the stop sample, SHALL return to IDLE immediately, so a new start edge is accepted from the next baud_pulse.
REQ-025 Re-arm after break or framing error: when fe=1, SHALL stay in IDLE disarmed until rx_s=1 is seen on a baud_pulse; no repeated frames during a held break.
REQ-026 wls and parity inputs SHALL be sampled when leaving START and held constant for the frame; mid-frame changes SHALL NOT affect it.
REQ-027 Clocks without baud_pulse SHALL change no state except the synchronizer and the push clear.

Reset
REQ-028 On rst: state=IDLE, counters=0, armed=1, synchronizer=11.
REQ-029 On rst: push=0, dout=8'h00, pe=0, fe=0, bi=0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no push; reception restarts on the next start edge after release.

Configuration
REQ-031 Macro UART_RX_MAJORITY_EN defined: each bit decision SHALL be the 2-of-3 majority of rx_s at sample pulses S-1, S, S+1.
  - The decision is taken at S+1 and all later samples are shifted by one pulse.
  - A false start is a start-bit majority of 1.
REQ-032 Macro UART_RX_MAJORITY_EN undefined: the decision SHALL be the single rx_s sample at pulse S.

Verification
REQ-033 8N1, wls=11, 0x55 sent at 16 pulses/bit -> one push, dout=0x55, pe=fe=bi=0.
REQ-034 7E1 (wls=10, pe_en=1, eps=1), 0x1A sent with parity bit 0 -> push, dout=0x1A, pe=1; with parity bit 1 -> pe=0.
REQ-035 5N1, 0x13 sent with stop bit 0 -> dout=0x13, fe=1, bi=0; the next valid frame 0x0A after rx high -> fe=0.
REQ-036 rx held low for 40 bit times, 8N1 -> exactly one push, dout=0x00, fe=1, bi=1; no further push until rx high and a new start.
REQ-037 rx low glitch of 4 pulses in IDLE -> no push, state back in IDLE; rst asserted during DATA of 0xA5 -> no push, outputs 0, the following 0x3C is received correctly.
